fp_mul_sequencer: RTL and testbench
===================================

Name: fp_mul_sequencer

Overview:
- Multi-cycle IEEE-754 single-precision multiplier controller for the FPU multiplier path.
- Accepts operand pairs over a valid/ready handshake and classifies special cases.
- Forms the biased exponent sum Ex+Ey-127, then sequences an internal radix-2 shift-add 24x24 mantissa multiply.
- Normalizes, rounds and packs the result, then holds it until the consumer accepts it.

Parameters:
- MUL_STEPS, 24, number of shift-add iterations. Must equal mantissa width including hidden bit. Fixed for single precision.
- BIAS, 127, exponent bias subtracted from Ex+Ey.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair (state IDLE).
- op_x  in  32  operand X, IEEE-754 single.
- op_y  in  32  operand Y, IEEE-754 single.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  32  product.
- flag_ovf  out  1  overflow, result forced to ±inf.
- flag_unf  out  1  underflow, result forced to ±0.
- flag_inv  out  1  invalid operation or NaN input, result is canonical NaN.
- busy  out  1  state not IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high; it overrides all other inputs on the same edge.
- Reset state: IDLE. in_ready=1, out_valid=0, result=0, all flags=0, busy=0, internal counter and accumulator cleared.
- Reset mid-operation: reset in any state discards the operation in flight; no out_valid is produced for it.
- Operand capture: on a clock edge with in_valid&in_ready, op_x and op_y are registered and the state moves to EXP. in_ready=0 in every state except IDLE.
- EXP (1 cycle):
  - Sign = Xs^Ys.
  - Exponent sum is computed 10-bit signed: Ex+Ey-BIAS.
  - Zero operand = exponent field 0. Denormals are flushed to zero.
  - Classification priority:
    1. NaN on either input → qNaN 0x7FC00000, flag_inv.
    2. 0×inf → qNaN 0x7FC00000, flag_inv.
    3. Inf on either input → ±inf.
    4. Zero on either input → ±0.
  - Special case: next state PACK with the result preloaded. Otherwise: next state MUL with counter=0.
- MUL (MUL_STEPS cycles):
  - Each cycle, if the multiplier LSB is 1, add the multiplicand into the 48-bit accumulator; shift right.
  - Counter increments each cycle; exit to NORM when counter==MUL_STEPS-1.
- NORM (1 cycle): if product bit47=1, take mantissa [46:24] and exponent+1; otherwise take [45:23]. Guard bit and sticky (OR of the remaining low bits) are retained.
- PACK (1 cycle):
  - Rounding is applied per the optional feature.
  - Round carry out of the mantissa → mantissa=0, exponent+1.
  - Final exponent ≥255 → {sign,0x7F800000[30:0]}, flag_ovf.
  - Final exponent ≤0 → {sign,31'b0}, flag_unf.
  - Next state OUT.
- OUT:
  - out_valid=1; result and flags are held stable until out_valid&out_ready.
  - On acceptance, go to IDLE with out_valid=0.
  - New input is never accepted in the same cycle as output acceptance; in_ready rises the cycle after.
- Latency, counted from the accept edge to the first cycle out_valid is high:
  - Normal operands: 27 edges (EXP 1 + MUL 24 + NORM 1 + PACK 1).
  - Special cases: 2 edges.
- Flags are mutually exclusive. They are cleared when the next operand pair is accepted.

Optional Feature:
- Macro: FP_MUL_RNE_EN.
- Defined: PACK applies round-to-nearest-even. Increment when guard=1 and (sticky=1 or mantissa LSB=1).
- Undefined: truncation (round toward zero). Guard and sticky are ignored, and their logic is omitted from the build.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic multiply: 0x40000000 × 0x40400000 → result 0x40C00000, no flags, out_valid exactly 27 cycles after the accept edge.
- Invalid operation: 0x00000000 × 0x7F800000 → 0x7FC00000, flag_inv=1, out_valid 2 cycles after accept.
- Overflow and underflow:
  - 0x7F000000 × 0x7F000000 → 0x7F800000, flag_ovf=1.
  - 0x00800000 × 0x80800000 → 0x80000000, flag_unf=1.
- Rounding: 0x3FC00000 × 0x3F800001 → 0x3FC00002 with FP_MUL_RNE_EN defined, 0x3FC00001 without it.
- Backpressure: out_ready held low 5 cycles after out_valid → result and flags stable, in_ready=0 with in_valid=1. On the acceptance cycle in_ready stays 0; it is 1 the following cycle.
- Reset mid-operation: rst asserted during MUL cycle 10 → next cycle IDLE, in_ready=1, out_valid=0. A fresh 0x3F800000 × 0x3F800000 then yields 0x3F800000 after 27 cycles.

Source files
------------

// File: rtl/fp_mul_sequencer_if.sv
// -----------------------------------------------------------------------------
// fp_mul_sequencer_if
// Purpose : bundles the operand/result handshake of the single-precision
//           multiplier sequencer.
// Signals :
//   in_valid / in_ready   operand pair handshake (producer -> sequencer)
//   op_x, op_y            IEEE-754 single operands
//   out_valid / out_ready result handshake (sequencer -> consumer)
//   result                IEEE-754 single product
//   flag_ovf/unf/inv      mutually exclusive status flags held with result
//   busy                  sequencer is not idle
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the multiplier sequencer itself
// -----------------------------------------------------------------------------
interface fp_mul_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_x;
  logic [31:0] op_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inv;
  logic        busy;

  modport master (
    output in_valid, op_x, op_y, out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv, busy
  );

  modport slave (
    input  in_valid, op_x, op_y, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv, busy
  );
endinterface

// File: rtl/fp_mul_sequencer.sv
// -----------------------------------------------------------------------------
// fp_mul_sequencer
// Purpose : multi-cycle IEEE-754 single-precision multiplier. Captures an
//           operand pair, classifies special operands, runs a radix-2
//           shift-add 24x24 mantissa multiply, normalizes, rounds, packs and
//           holds the result until the consumer accepts it.
// Ports   :
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, discards any operation in flight
//   bus  : fp_mul_sequencer_if.slave (operand/result handshakes, flags, busy)
// Build option:
//   FP_MUL_RNE_EN defined   -> round-to-nearest-even in PACK
//   FP_MUL_RNE_EN undefined -> truncation; guard/sticky logic is not built
// Denormal operands are flushed to zero. Latency from accept edge to
// out_valid: 27 edges for normal operands, 2 edges for special cases.
// -----------------------------------------------------------------------------
module fp_mul_sequencer #(
  parameter int MUL_STEPS = 24,
  parameter int BIAS      = 127
) (
  input logic                 clk,
  input logic                 rst,
  fp_mul_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXP,
    S_MUL,
    S_NORM,
    S_PACK,
    S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        op_x_q, op_x_d;
  logic [31:0]        op_y_q, op_y_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [47:0]        prod_q, prod_d;
  logic [22:0]        mant_q, mant_d;
  logic               special_q, special_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               inv_q, inv_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
`ifdef FP_MUL_RNE_EN
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
`endif

  // Operand classification; a zero exponent field covers denormals too.
  logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  assign x_zero = (op_x_q[30:23] == 8'h00);
  assign y_zero = (op_y_q[30:23] == 8'h00);
  assign x_inf  = (op_x_q[30:23] == 8'hFF) && (op_x_q[22:0] == 23'd0);
  assign y_inf  = (op_y_q[30:23] == 8'hFF) && (op_y_q[22:0] == 23'd0);
  assign x_nan  = (op_x_q[30:23] == 8'hFF) && (op_x_q[22:0] != 23'd0);
  assign y_nan  = (op_y_q[30:23] == 8'hFF) && (op_y_q[22:0] != 23'd0);

  logic              prod_sign;
  logic signed [9:0] exp_sum;
  assign prod_sign = op_x_q[31] ^ op_y_q[31];
  assign exp_sum   = 10'({2'b00, op_x_q[30:23]}) + 10'({2'b00, op_y_q[30:23]})
                   - 10'(BIAS);

  // One shift-add step: the multiplier sits in the low half of prod_q and is
  // consumed LSB first while partial sums enter from the top.
  logic [23:0] mcand;
  logic [24:0] mul_sum;
  assign mcand   = {1'b1, op_x_q[22:0]};
  assign mul_sum = {1'b0, prod_q[47:24]} + (prod_q[0] ? {1'b0, mcand} : 25'd0);

  // Rounding increment; a carry into bit 23 means the mantissa wrapped to
  // 1.0 x 2^(e+1), so the stored fraction becomes zero.
  logic [23:0]       mant_rnd;
  logic signed [9:0] exp_fin;
`ifdef FP_MUL_RNE_EN
  logic round_inc;
  assign round_inc = guard_q & (sticky_q | mant_q[0]);
  assign mant_rnd  = {1'b0, mant_q} + {23'd0, round_inc};
`else
  assign mant_rnd  = {1'b0, mant_q};
`endif
  assign exp_fin = mant_rnd[23] ? (exp_q + 10'sd1) : exp_q;

  always_comb begin
    state_d   = state_q;
    op_x_d    = op_x_q;
    op_y_d    = op_y_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mant_d    = mant_q;
    special_d = special_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    inv_d     = inv_q;
`ifdef FP_MUL_RNE_EN
    guard_d   = guard_q;
    sticky_d  = sticky_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_x_d  = bus.op_x;
          op_y_d  = bus.op_y;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = S_EXP;
        end
      end

      S_EXP: begin
        sign_d    = prod_sign;
        exp_d     = exp_sum;
        cnt_d     = 5'd0;
        prod_d    = {24'd0, 1'b1, op_y_q[22:0]};
        special_d = 1'b1;
        state_d   = S_PACK;
        if (x_nan || y_nan || (x_zero && y_inf) || (x_inf && y_zero)) begin
          result_d = 32'h7FC0_0000;
          inv_d    = 1'b1;
        end else if (x_inf || y_inf) begin
          result_d = {prod_sign, 8'hFF, 23'd0};
        end else if (x_zero || y_zero) begin
          result_d = {prod_sign, 31'd0};
        end else begin
          special_d = 1'b0;
          state_d   = S_MUL;
        end
      end

      S_MUL: begin
        prod_d = {mul_sum, prod_q[23:1]};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'(MUL_STEPS - 1)) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (prod_q[47]) begin
          mant_d   = prod_q[46:24];
          exp_d    = exp_q + 10'sd1;
`ifdef FP_MUL_RNE_EN
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
`endif
        end else begin
          mant_d   = prod_q[45:23];
`ifdef FP_MUL_RNE_EN
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
`endif
        end
        state_d = S_PACK;
      end

      S_PACK: begin
        if (!special_q) begin
          if (exp_fin >= 10'sd255) begin
            result_d = {sign_q, 31'h7F80_0000};
            ovf_d    = 1'b1;
          end else if (exp_fin <= 10'sd0) begin
            result_d = {sign_q, 31'd0};
            unf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_fin[7:0], mant_rnd[22:0]};
          end
        end
        state_d = S_OUT;
      end

      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered from the next state so they line up
    // with the state they describe.
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_x_q      <= 32'd0;
      op_y_q      <= 32'd0;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      cnt_q       <= 5'd0;
      prod_q      <= 48'd0;
      mant_q      <= 23'd0;
      special_q   <= 1'b0;
      result_q    <= 32'd0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FP_MUL_RNE_EN
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mant_q      <= mant_d;
      special_q   <= special_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef FP_MUL_RNE_EN
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_ovf  = ovf_q;
  assign bus.flag_unf  = unf_q;
  assign bus.flag_inv  = inv_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_sequencer
// Purpose : self-checking bench for fp_mul_sequencer. Directed vectors from a
//           table, hand-written backpressure and reset-in-flight sequences,
//           then random operand pairs compared against an arithmetic model.
// Honours FP_MUL_RNE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fp_mul_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_mul_sequencer_if bus ();

  fp_mul_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Reference model: exact integer product of the significands, normalized
  // and rounded by comparing the discarded remainder against one half ulp.
  task automatic ref_model(input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] res, output logic [2:0] flags,
                           output int lat);
    int     ex, ey, e, shift;
    logic   s;
    logic   xz, yz, xi, yi, xn, yn;
    longint p, m;
`ifdef FP_MUL_RNE_EN
    longint rem, half;
`endif
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    flags = 3'b000;
    lat   = 2;
    if (xn || yn || (xz && yi) || (xi && yz)) begin
      res   = 32'h7FC0_0000;
      flags = 3'b001;
    end else if (xi || yi) begin
      res = {s, 8'hFF, 23'd0};
    end else if (xz || yz) begin
      res = {s, 31'd0};
    end else begin
      lat = 27;
      p   = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      e   = ex + ey - 127;
      if (p >= (64'sd1 <<< 47)) begin
        shift = 24;
        e     = e + 1;
      end else begin
        shift = 23;
      end
      m = p >>> shift;
`ifdef FP_MUL_RNE_EN
      rem  = p - (m <<< shift);
      half = 64'sd1 <<< (shift - 1);
      if (rem > half || (rem == half && m[0])) m = m + 1;
`endif
      if (m >= (64'sd1 <<< 24)) begin
        m = m >>> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        res   = {s, 31'h7F80_0000};
        flags = 3'b100;
      end else if (e <= 0) begin
        res   = {s, 31'd0};
        flags = 3'b010;
      end else begin
        res = {s, e[7:0], m[22:0]};
      end
    end
  endtask

  // Issue one operand pair, measure latency, check result/flags, accept it.
  task automatic applyStimulus(input string name, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] exp_res,
                               input logic [2:0] exp_flags, input int exp_lat);
    int  wait_cnt;
    int  lat;
    logic got;
    wait_cnt = 0;
    while (!bus.in_ready && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (wait_cnt >= 100) checkOutput({name, " in_ready timeout"}, 32'd0, 32'd1);
    bus.op_x     = x;
    bus.op_y     = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    checkOutput({name, " latency"}, lat, exp_lat);
    checkOutput({name, " result"}, bus.result, exp_res);
    checkOutput({name, " flags"}, {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inv},
                {29'd0, exp_flags});
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rx, ry, rres;
    logic [2:0]  rflags;
    int          rlat;
    int          seen;
    logic [31:0] held;

    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_x      = 32'd0;
    bus.op_y      = 32'd0;

    vecs[0] = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 27};
    vecs[1] = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b001, 2};
    vecs[2] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b100, 27};
    vecs[3] = '{32'h0080_0000, 32'h8080_0000, 32'h8000_0000, 3'b010, 27};
`ifdef FP_MUL_RNE_EN
    vecs[4] = '{32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 3'b000, 27};
`else
    vecs[4] = '{32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0001, 3'b000, 27};
`endif
    vecs[5] = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b001, 2};
    vecs[6] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000, 2};
    vecs[7] = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3'b000, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    checkOutput("reset flags", {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inv}, 32'd0);
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].res,
                    vecs[i].flags, vecs[i].lat);
    end

    // Backpressure: result held for 5 cycles while a new pair is offered.
    bus.op_x     = 32'h4000_0000;
    bus.op_y     = 32'h4040_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    seen = 0;
    while (!bus.out_valid && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    checkOutput("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
    held = bus.result;
    bus.op_x     = 32'h3F80_0000;
    bus.op_y     = 32'h3F80_0000;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp result c%0d", k), bus.result, 32'h40C0_0000);
      checkOutput($sformatf("bp flags c%0d", k),
                  {29'd0, bus.flag_ovf, bus.flag_unf, bus.flag_inv}, 32'd0);
      checkOutput($sformatf("bp in_ready c%0d", k), {31'd0, bus.in_ready}, 32'd0);
      checkOutput($sformatf("bp out_valid c%0d", k), {31'd0, bus.out_valid}, 32'd1);
    end
    checkOutput("bp held", held, 32'h40C0_0000);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp accept in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
    end
    @(negedge clk);
    checkOutput("bp after in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("bp after out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Reset while the multiply loop is at iteration 10.
    bus.op_x     = 32'h4000_0000;
    bus.op_y     = 32'h4040_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midrst busy", {31'd0, bus.busy}, 32'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checkOutput("midrst no output", seen, 32'd0);
    applyStimulus("after reset", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 27);

    // Random operands with biased exponent classes.
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < 2; j++) begin
        logic [31:0] v;
        int cls;
        v   = $urandom;
        cls = int'($urandom_range(0, 9));
        case (cls)
          0: v[30:23] = 8'h00;
          1: begin
            v[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
          end
          2: v[30:23] = 8'($urandom_range(200, 254));
          3: v[30:23] = 8'($urandom_range(1, 50));
          default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        if (j == 0) rx = v;
        else        ry = v;
      end
      ref_model(rx, ry, rres, rflags, rlat);
      applyStimulus($sformatf("rand%0d %h*%h", n, rx, ry), rx, ry, rres, rflags, rlat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
